// File: rtl/cci_mpf_rd_arb_pkg.sv
// ----------------------------------------------------------------------------
// cci_mpf_rd_arb_pkg
//
// Shared types for the channel-0 read arbiter.
//   t_cci_clAddr / t_cci_mdata / t_cci_clData : CCI field widths (42/16/512)
//   t_req_id            : requester index, sized for the largest requester count
//   t_rd_arb_tag        : locally owned read tag at the default tag width
//   t_rd_arb_meta       : what the tag table remembers per tag {req id, mdata}
//   t_rd_arb_fl_state   : free-list FSM state (INIT fill, then RUN)
// ----------------------------------------------------------------------------
package cci_mpf_rd_arb_pkg;

   localparam int CCI_CLADDR_WIDTH        = 42;
   localparam int CCI_MDATA_WIDTH         = 16;
   localparam int CCI_CLDATA_WIDTH        = 512;
   localparam int CCI_MPF_RD_ARB_MAX_REQ  = 4;
   localparam int CCI_MPF_RD_ARB_TAG_BITS = 6;

   typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_clAddr;
   typedef logic [CCI_MDATA_WIDTH-1:0]  t_cci_mdata;
   typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_clData;

   typedef logic [$clog2(CCI_MPF_RD_ARB_MAX_REQ)-1:0] t_req_id;
   typedef logic [CCI_MPF_RD_ARB_TAG_BITS-1:0]        t_rd_arb_tag;

   typedef struct packed {
      t_req_id    req_id;
      t_cci_mdata mdata;
   } t_rd_arb_meta;

   typedef enum logic {
      FL_INIT = 1'b0,
      FL_RUN  = 1'b1
   } t_rd_arb_fl_state;

endpackage

// File: rtl/cci_mpf_rd_arb_freelist.sv
// ----------------------------------------------------------------------------
// cci_mpf_rd_arb_freelist
//
// FIFO of free read tags. After reset the FSM sits in INIT and writes tags
// 0..2^TAG_BITS-1 into the FIFO, one per cycle, then moves to RUN.
//   clk, reset : clock, synchronous active-high reset
//   push       : return push_tag to the tail (honoured in RUN only)
//   pop        : consume pop_tag from the head (caller checks empty)
//   pop_tag    : head of the FIFO, valid whenever !empty
//   empty      : no free tag available this cycle
//   init_done  : FIFO fully populated, FSM in RUN
//   state      : current FSM state, exported for observation
// ----------------------------------------------------------------------------
module cci_mpf_rd_arb_freelist
   import cci_mpf_rd_arb_pkg::*;
#(
   parameter int TAG_BITS = 6
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                push,
   input  logic [TAG_BITS-1:0] push_tag,
   input  logic                pop,
   output logic [TAG_BITS-1:0] pop_tag,
   output logic                empty,
   output logic                init_done,
   output t_rd_arb_fl_state    state
);

   localparam int DEPTH = 1 << TAG_BITS;

   logic [TAG_BITS-1:0] mem [DEPTH];
   logic [TAG_BITS-1:0] rd_ptr;
   logic [TAG_BITS-1:0] wr_ptr;
   logic [TAG_BITS-1:0] init_cnt;
   logic [TAG_BITS:0]   count;

   // Pointers wrap naturally at DEPTH; count distinguishes full from empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FL_INIT;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         init_cnt <= '0;
         count    <= '0;
      end else begin
         case (state)
            FL_INIT: begin
               wr_ptr   <= wr_ptr + 1'b1;
               count    <= count + 1'b1;
               init_cnt <= init_cnt + 1'b1;
               if (&init_cnt) state <= FL_RUN;
            end
            FL_RUN: begin
               if (push) wr_ptr <= wr_ptr + 1'b1;
               if (pop)  rd_ptr <= rd_ptr + 1'b1;
               if (push && !pop)      count <= count + 1'b1;
               else if (pop && !push) count <= count - 1'b1;
            end
            default: state <= FL_INIT;
         endcase
      end
   end

   // Storage carries no reset; INIT rewrites every entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == FL_INIT)  mem[wr_ptr] <= init_cnt;
         else if (push)         mem[wr_ptr] <= push_tag;
      end
   end

   // A tag pushed this cycle only lands in count at the edge, so it cannot be
   // popped before the following cycle.
   assign pop_tag   = mem[rd_ptr];
   assign empty     = (count == '0);
   assign init_done = (state == FL_RUN);

endmodule

// File: rtl/cci_mpf_c0_rd_arb.sv
// ----------------------------------------------------------------------------
// cci_mpf_c0_rd_arb
//
// Round-robin arbiter sharing the MPF channel-0 read-request path among N_REQ
// requesters. Each granted request gets a locally owned tag in its mdata; the
// tag table remembers {requester, original mdata} so c0Rx responses can be
// routed back with the original mdata restored. Single-line reads only.
//
// Handshake: req_valid[i] is held by requester i until req_grant[i] is seen
// high in the same cycle; req_grant is combinational and means the address and
// mdata were consumed at the next clock edge. The FIU side has no ready: it is
// throttled only by fiu_c0_almfull, sampled in the grant cycle.
//
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   req_valid/addr/mdata      : per-requester read requests (flattened)
//   req_grant                 : one-hot, request consumed this cycle
//   fiu_c0_valid/addr/mdata   : registered request toward the FIU
//   fiu_c0_almfull            : FIU c0TxAlmFull
//   fiu_rx_valid/mdata/data   : c0Rx read response, tag in mdata low bits
//   rsp_valid/mdata/data      : registered response to the owning requester
//   outstanding               : tags in flight
//   init_done                 : free list populated
//
// Optional build macro CCI_MPF_RD_ARB_STATS_EN adds stat_grants (saturating
// per-requester grant counters) and stat_stall_cycles (RUN cycles with some
// request pending but no grant).
// ----------------------------------------------------------------------------
module cci_mpf_c0_rd_arb
   import cci_mpf_rd_arb_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int TAG_BITS = 6
)
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*CCI_CLADDR_WIDTH-1:0] req_addr,
   input  logic [N_REQ*CCI_MDATA_WIDTH-1:0]  req_mdata,
   output logic [N_REQ-1:0]              req_grant,
   output logic                          fiu_c0_valid,
   output t_cci_clAddr                   fiu_c0_addr,
   output t_cci_mdata                    fiu_c0_mdata,
   input  logic                          fiu_c0_almfull,
   input  logic                          fiu_rx_valid,
   input  t_cci_mdata                    fiu_rx_mdata,
   input  t_cci_clData                   fiu_rx_data,
   output logic [N_REQ-1:0]              rsp_valid,
   output t_cci_mdata                    rsp_mdata,
   output t_cci_clData                   rsp_data,
   output logic [TAG_BITS:0]             outstanding,
   output logic                          init_done
`ifdef CCI_MPF_RD_ARB_STATS_EN
   ,
   output logic [N_REQ*32-1:0]           stat_grants,
   output logic [31:0]                   stat_stall_cycles
`endif
);

   localparam int N_TAGS = 1 << TAG_BITS;

   t_rd_arb_fl_state    fl_state;
   logic                run;
   logic                fl_empty;
   logic [TAG_BITS-1:0] pop_tag;
   logic [TAG_BITS-1:0] rx_tag;
   logic                rx_fire;
   logic                can_issue;
   logic                grant_any;
   t_req_id             grant_id;
   t_req_id             rr_ptr;
   t_cci_clAddr         grant_addr;
   t_cci_mdata          grant_mdata;
   logic [2*N_REQ-1:0]  req_dbl;
   t_rd_arb_meta        tag_table [N_TAGS];
   t_rd_arb_meta        rx_meta;
   logic [N_TAGS-1:0]   tag_busy;
   logic                unused_rx_mdata_hi;

   assign run       = (fl_state == FL_RUN);
   assign rx_tag    = fiu_rx_mdata[TAG_BITS-1:0];
   // Responses outside RUN belong to a pre-reset epoch and are dropped.
   assign rx_fire   = run && fiu_rx_valid;
   assign can_issue = run && !fiu_c0_almfull && !fl_empty;
   assign req_dbl   = {req_valid, req_valid};
   assign rx_meta   = tag_table[rx_tag];
   assign unused_rx_mdata_hi = ^fiu_rx_mdata[CCI_MDATA_WIDTH-1:TAG_BITS];

   cci_mpf_rd_arb_freelist #(.TAG_BITS(TAG_BITS)) freelist (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_fire),
      .push_tag  (rx_tag),
      .pop       (grant_any),
      .pop_tag   (pop_tag),
      .empty     (fl_empty),
      .init_done (init_done),
      .state     (fl_state)
   );

   // Scanning the doubled request vector from rr_ptr upward finds the first
   // requester at or after the pointer, wrapping once.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      for (int i = 0; i < 2*N_REQ; i++) begin
         if (can_issue && !grant_any && (i >= int'(rr_ptr)) && req_dbl[i]) begin
            grant_any = 1'b1;
            grant_id  = t_req_id'(i % N_REQ);
         end
      end
   end

   always_comb begin
      req_grant   = '0;
      grant_addr  = '0;
      grant_mdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_any && (grant_id == t_req_id'(i))) begin
            req_grant[i] = 1'b1;
            grant_addr   = req_addr[i*CCI_CLADDR_WIDTH +: CCI_CLADDR_WIDTH];
            grant_mdata  = req_mdata[i*CCI_MDATA_WIDTH +: CCI_MDATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr       <= '0;
         fiu_c0_valid <= 1'b0;
         fiu_c0_addr  <= '0;
         fiu_c0_mdata <= '0;
         rsp_valid    <= '0;
         rsp_mdata    <= '0;
         rsp_data     <= '0;
         outstanding  <= '0;
         tag_busy     <= '0;
      end else begin
         fiu_c0_valid <= grant_any;
         if (grant_any) begin
            fiu_c0_addr  <= grant_addr;
            fiu_c0_mdata <= t_cci_mdata'(pop_tag);
            rr_ptr       <= (grant_id == t_req_id'(N_REQ-1)) ? '0 : grant_id + 1'b1;
            tag_busy[pop_tag] <= 1'b1;
         end

         rsp_valid <= '0;
         if (rx_fire) begin
            for (int i = 0; i < N_REQ; i++)
               rsp_valid[i] <= (rx_meta.req_id == t_req_id'(i));
            rsp_mdata <= rx_meta.mdata;
            rsp_data  <= fiu_rx_data;
            tag_busy[rx_tag] <= 1'b0;
         end

         case ({grant_any, rx_fire})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Tag table: plain RAM, contents meaningful only for allocated tags.
   always_ff @(posedge clk) begin
      if (grant_any) tag_table[pop_tag] <= '{req_id: grant_id, mdata: grant_mdata};
   end

   // A response must carry a tag that is currently allocated.
   rx_tag_allocated: assert property (@(posedge clk) disable iff (reset)
      rx_fire |-> tag_busy[rx_tag]);

`ifdef CCI_MPF_RD_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_grants       <= '0;
         stat_stall_cycles <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_grant[i] && (stat_grants[i*32 +: 32] != '1))
               stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
         end
         if (run && (|req_valid) && !grant_any && (stat_stall_cycles != '1))
            stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cci_mpf_c0_rd_arb.sv
// ----------------------------------------------------------------------------
// tb_cci_mpf_c0_rd_arb
//
// Directed bench for cci_mpf_c0_rd_arb (N_REQ=2, TAG_BITS=6). The driver
// checks req_grant and outstanding each cycle against hand-chosen values and
// pushes the expected FIU request / requester response into queues; the
// monitor pops and compares whenever fiu_c0_valid or rsp_valid is seen.
// ----------------------------------------------------------------------------
module tb_cci_mpf_c0_rd_arb;

   localparam int N       = 2;
   localparam int TB_BITS = 6;
   localparam int NT      = 64;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid;
   logic [N*42-1:0] req_addr;
   logic [N*16-1:0] req_mdata;
   logic [N-1:0]    req_grant;
   logic            fiu_c0_valid;
   logic [41:0]     fiu_c0_addr;
   logic [15:0]     fiu_c0_mdata;
   logic            fiu_c0_almfull;
   logic            fiu_rx_valid;
   logic [15:0]     fiu_rx_mdata;
   logic [511:0]    fiu_rx_data;
   logic [N-1:0]    rsp_valid;
   logic [15:0]     rsp_mdata;
   logic [511:0]    rsp_data;
   logic [TB_BITS:0] outstanding;
   logic            init_done;
`ifdef CCI_MPF_RD_ARB_STATS_EN
   logic [N*32-1:0] stat_grants;
   logic [31:0]     stat_stall_cycles;
`endif

   cci_mpf_c0_rd_arb #(.N_REQ(N), .TAG_BITS(TB_BITS)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_mdata      (req_mdata),
      .req_grant      (req_grant),
      .fiu_c0_valid   (fiu_c0_valid),
      .fiu_c0_addr    (fiu_c0_addr),
      .fiu_c0_mdata   (fiu_c0_mdata),
      .fiu_c0_almfull (fiu_c0_almfull),
      .fiu_rx_valid   (fiu_rx_valid),
      .fiu_rx_mdata   (fiu_rx_mdata),
      .fiu_rx_data    (fiu_rx_data),
      .rsp_valid      (rsp_valid),
      .rsp_mdata      (rsp_mdata),
      .rsp_data       (rsp_data),
      .outstanding    (outstanding),
      .init_done      (init_done)
`ifdef CCI_MPF_RD_ARB_STATS_EN
      ,
      .stat_grants       (stat_grants),
      .stat_stall_cycles (stat_stall_cycles)
`endif
   );

   // ---------------- scoreboard state ----------------
   logic [57:0]  exp_q[$];      // {addr, mdata} expected on the FIU request port
   logic [529:0] exp_rsp_q[$];  // {rsp_valid, mdata, data} expected on the response
   int free_q[$];
   int alloc_q[$];
   logic [1:0]  mdl_id [NT];
   logic [15:0] mdl_md [NT];
   int mdl_out;
   bit mdl_run;
   int checks;
   int errors;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      free_q.delete();
      alloc_q.delete();
      for (int t = 0; t < NT; t++) free_q.push_back(t);
      mdl_out = 0;
      mdl_run = 1'b0;
   endtask

   // One cycle: inputs were set by the caller at the preceding negedge.
   task automatic tick(input logic [N-1:0] exp_g);
      int id;
      int tag;
      logic [N-1:0] oh;
      #1;
      chk("grant", 64'(req_grant), 64'(exp_g));
      chk("outstanding", 64'(outstanding), 64'(mdl_out));
      if (exp_g != '0) begin
         id = exp_g[1] ? 1 : 0;
         if (free_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL model_free_tag actual=none required=tag");
         end else begin
            tag = free_q.pop_front();
            exp_q.push_back({req_addr[id*42 +: 42], 16'(tag)});
            mdl_id[tag] = 2'(id);
            mdl_md[tag] = req_mdata[id*16 +: 16];
            alloc_q.push_back(tag);
            mdl_out++;
         end
      end
      if (fiu_rx_valid && mdl_run) begin
         tag = int'(fiu_rx_mdata[TB_BITS-1:0]);
         oh = '0;
         oh[mdl_id[tag]] = 1'b1;
         exp_rsp_q.push_back({oh, mdl_md[tag], fiu_rx_data});
         free_q.push_back(tag);
         mdl_out--;
      end
      @(negedge clk);
   endtask

   task automatic set_rx(input int tag, input logic [511:0] d);
      for (int j = 0; j < alloc_q.size(); j++) begin
         if (alloc_q[j] == tag) begin
            alloc_q.delete(j);
            break;
         end
      end
      fiu_rx_valid = 1'b1;
      fiu_rx_mdata = 16'(tag);
      fiu_rx_data  = d;
   endtask

   task automatic set_rx_oldest();
      int tag;
      tag = alloc_q[0];
      set_rx(tag, {16{32'(tag) ^ 32'h5A5A0000}});
   endtask

   task automatic rx_off();
      fiu_rx_valid = 1'b0;
      fiu_rx_mdata = '0;
      fiu_rx_data  = '0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [57:0]  e;
      logic [529:0] r;
      if (fiu_c0_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected actual=%h_%h required=none", fiu_c0_addr, fiu_c0_mdata);
         end else begin
            e = exp_q.pop_front();
            if ({fiu_c0_addr, fiu_c0_mdata} !== e) begin
               errors++;
               $display("FAIL issue actual=%h_%h required=%h_%h", fiu_c0_addr, fiu_c0_mdata, e[57:16], e[15:0]);
            end
         end
      end
      if (rsp_valid !== '0) begin
         checks++;
         if (exp_rsp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected actual=%b_%h required=none", rsp_valid, rsp_mdata);
         end else begin
            r = exp_rsp_q.pop_front();
            if ({rsp_valid, rsp_mdata, rsp_data} !== r) begin
               errors++;
               $display("FAIL rsp actual=%b_%h_%h required=%b_%h_%h", rsp_valid, rsp_mdata, rsp_data,
                        r[529:528], r[527:512], r[511:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int out_before;
      checks = 0;
      errors = 0;
      req_valid      = 2'b11;
      req_addr       = {42'h2_0000_0B00, 42'h1_0000_0A00};
      req_mdata      = {16'h2000, 16'h1000};
      fiu_c0_almfull = 1'b0;
      rx_off();
      model_reset();

      // Reset values, with requests already pending.
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_fiu_valid", 64'(fiu_c0_valid), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_grant", 64'(req_grant), 64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_init_done", 64'(init_done), 64'd0);

      // INIT: 64 cycles of no grants, init_done rises after the 64th edge.
      reset = 1'b0;
      for (int k = 1; k <= NT; k++) begin
         if (k == NT) chk("init_done_c63", 64'(init_done), 64'd0);
         tick(2'b00);
      end
      chk("init_done_c64", 64'(init_done), 64'd1);
      mdl_run = 1'b1;

      // Alternating grants, tags 0..3.
      for (int k = 0; k < 4; k++) begin
         req_mdata = {16'h2000 + 16'(k), 16'h1000 + 16'(k)};
         tick((k % 2 == 0) ? 2'b01 : 2'b10);
      end

      // Req1 takes tag 4, req0 with 0xABCD takes tag 5.
      req_valid = 2'b10;
      tick(2'b10);
      req_valid = 2'b01;
      req_mdata = {16'h2222, 16'hABCD};
      tick(2'b01);
      req_valid = 2'b00;
      tick(2'b00);
      chk("tag5_issue_mdata", 64'(fiu_c0_mdata), 64'h0005);
      set_rx(5, {16{32'h11111111}});
      tick(2'b00);
      rx_off();
      chk("tag5_rsp_valid", 64'(rsp_valid), 64'b01);
      chk("tag5_rsp_mdata", 64'(rsp_mdata), 64'hABCD);
      chk("tag5_outstanding", 64'(outstanding), 64'd5);

      // Return everything in flight.
      while (alloc_q.size() > 0) begin
         set_rx_oldest();
         tick(2'b00);
      end
      rx_off();
      tick(2'b00);
      chk("drained_outstanding", 64'(outstanding), 64'd0);

      // Exhaust all 64 tags; pointer sits at req1 after the tag-5 grant.
      req_valid = 2'b11;
      for (int k = 0; k < NT; k++) begin
         req_mdata = {16'h3000 + 16'(k), 16'h4000 + 16'(k)};
         tick((k % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick(2'b00);
      tick(2'b00);
      chk("full_outstanding", 64'(outstanding), 64'd64);
      set_rx_oldest();
      tick(2'b00);               // freed tag not grantable in its own cycle
      rx_off();
      tick(2'b10);
      tick(2'b00);
      chk("full_again", 64'(outstanding), 64'd64);

      // Free four tags with no requests pending.
      req_valid = 2'b00;
      repeat (4) begin
         set_rx_oldest();
         tick(2'b00);
      end
      rx_off();

      // Almost-full: grant before assertion still issues, pointer holds.
      req_valid = 2'b11;
      req_mdata = {16'h5151, 16'h5050};
      tick(2'b01);
      fiu_c0_almfull = 1'b1;
      repeat (10) tick(2'b00);
      fiu_c0_almfull = 1'b0;
      tick(2'b10);
      tick(2'b01);
      req_valid = 2'b00;
      tick(2'b00);
      chk("almfull_outstanding", 64'(outstanding), 64'd63);

      // Simultaneous grant and response.
      out_before = mdl_out;
      req_valid = 2'b01;
      req_mdata = {16'h6161, 16'h6060};
      set_rx_oldest();
      tick(2'b01);
      rx_off();
      req_valid = 2'b00;
      chk("simul_outstanding", 64'(outstanding), 64'(out_before));
      tick(2'b00);

      // Reset mid-flight with requests pending.
      req_valid = 2'b11;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_fiu_valid", 64'(fiu_c0_valid), 64'd0);
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
      chk("mid_rst_init_done", 64'(init_done), 64'd0);
      chk("mid_rst_grant", 64'(req_grant), 64'd0);
      reset = 1'b0;
      model_reset();
      for (int k = 1; k <= NT; k++) begin
         if (k == 10) begin
            fiu_rx_valid = 1'b1;     // dropped: arrives during INIT
            fiu_rx_mdata = 16'h0003;
            fiu_rx_data  = {16{32'hDEADBEEF}};
         end
         tick(2'b00);
         if (k == 10) rx_off();
      end
      chk("reinit_done", 64'(init_done), 64'd1);
      mdl_run = 1'b1;
      req_mdata = {16'h7171, 16'h7070};
      tick(2'b01);               // pointer back at 0, tag 0
      req_valid = 2'b00;
      tick(2'b00);
      chk("reinit_tag0", 64'(fiu_c0_mdata), 64'h0000);
      tick(2'b00);

      chk("issue_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("rsp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cci_mpf_c0_rd_arb.md
Name: cci_mpf_c0_rd_arb

Overview:
- Shares the MPF channel-0 read-request path toward the FIU among N_REQ requesters.
- Round-robin arbitration; c0TxAlmFull back-pressure honoured; mdata remapped to a locally owned tag; c0Rx read responses routed back to the originating requester with its original mdata restored.
- Sits on the AFU side of an MPF to_fiu connection; single-line reads only.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- TAG_BITS, 6, tag width; outstanding limit is 2^TAG_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester read request
- req_addr  in  N_REQ*42  cache-line address per requester
- req_mdata  in  N_REQ*16  requester metadata
- req_grant  out  N_REQ  one-hot; request consumed this cycle
- fiu_c0_valid  out  1  read request to FIU
- fiu_c0_addr  out  42  granted address
- fiu_c0_mdata  out  16  {zeros, tag}
- fiu_c0_almfull  in  1  FIU c0TxAlmFull
- fiu_rx_valid  in  1  c0Rx read response valid
- fiu_rx_mdata  in  16  response mdata (tag in low TAG_BITS)
- fiu_rx_data  in  512  response line
- rsp_valid  out  N_REQ  one-hot response to requester
- rsp_mdata  out  16  restored original mdata
- rsp_data  out  512  response line
- outstanding  out  TAG_BITS+1  tags currently in flight
- init_done  out  1  free list populated

Behaviour:
- Reset is synchronous and active-high; there is one clock.
- Reset values: all valid, grant and rsp outputs 0; outstanding 0; init_done 0; RR pointer 0; tag table contents don't-care.
- FSM INIT: a counter pushes tags 0..2^TAG_BITS-1 into the free FIFO, one per cycle. After 2^TAG_BITS cycles the FSM moves to RUN and init_done rises. No grants are issued in INIT.
- FSM RUN: can_issue = !fiu_c0_almfull && free FIFO not empty.
- Grant: if can_issue, the first requester with req_valid at or after the RR pointer is granted (combinational req_grant). The RR pointer then moves to granted+1 mod N_REQ. The pointer is unchanged when there is no grant.
- On grant: pop tag; write table[tag] = {requester id, req_mdata}.
- Issue latency: fiu_c0_valid/addr/mdata are registered and appear one cycle after the grant.
- Almost-full: sampled in the grant cycle. A request already registered is still issued; the FIU slack covers it.
- Response latency: on fiu_rx_valid, look up table[fiu_rx_mdata[TAG_BITS-1:0]]. rsp_valid[id], rsp_mdata and rsp_data are registered one cycle later. The tag is pushed back into the free FIFO in that same cycle.
- outstanding: +1 on grant, -1 on response. Simultaneous grant and response leaves it unchanged. A tag freed this cycle is not grantable until the next cycle.
- Full: at 2^TAG_BITS outstanding the free FIFO is empty and all grants stall. Requesters keep their req_valid asserted.
- A response with an unallocated tag is a protocol error, flagged by simulation assertion; the block routes whatever the table holds.
- Reset mid-operation: FSM returns to INIT and all in-flight state is discarded. Responses arriving during INIT are dropped, and the FIU must be drained by the system reset.

Optional Feature:
- CCI_MPF_RD_ARB_STATS_EN
- Defined: adds output stat_grants (N_REQ*32) with a saturating per-requester grant counter, and stat_stall_cycles (32) counting RUN cycles with any req_valid but no grant. Both are cleared by reset.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package cci_mpf_rd_arb_pkg:
  - t_cci_clAddr (42b), t_cci_mdata (16b), t_cci_clData (512b) widths;
  - t_rd_arb_tag;
  - t_rd_arb_meta struct {req id, mdata};
  - CCI_MPF_RD_ARB_MAX_REQ = 4.
- Sub-module cci_mpf_rd_arb_freelist: tag FIFO with INIT fill counter, push/pop and empty flag. The tag table stays in the top as a simple RAM.

Test Plan:
- Reset then idle: init_done rises at cycle 64 after reset deassert; no grants before it; outstanding = 0.
- Two requesters always valid, no almfull: grants alternate 0,1,0,1. fiu_c0_mdata tags are 0,1,2,3, each one cycle after grant.
- Req0 mdata 0xABCD granted tag 5; fiu_rx_valid with mdata 0x0005, data 0x11..: next cycle rsp_valid=2'b01, rsp_mdata=0xABCD, tag 5 returned.
- Hold responses, req always valid: exactly 64 grants, then req_grant=0 and outstanding=64. One response restores one grant next cycle.
- fiu_c0_almfull asserted for 10 cycles: zero grants in those cycles. The request registered before assertion still issues. Arbitration resumes from the unchanged RR pointer.
- Simultaneous grant and response in one cycle: outstanding unchanged. Reset asserted mid-flight: outputs zero next cycle, then INIT repeats.
